// File: rtl/lsu_load.sv
// Load unit: accepts one load request, issues a single AXI-lite word read,
// extracts and extends the addressed byte/half/word, and returns it to writeback.
module lsu_load (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [4:0]  req_rd,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_RESP = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    lo_q, lo_d;
   logic [AW-1:0] araddr_q, araddr_d;
   logic [DW-1:0] data_q, data_d;
   logic [RW-1:0] rd_q, rd_d;
   logic          err_q, err_d;
   logic          req_ready_q, arvalid_q, rready_q, resp_valid_q, busy_q;

   logic          req_legal, req_misal;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [DW-1:0] ext_v;

   // Request legality and alignment decode
   always_comb begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                  (req_funct3 == 3'b101);
      req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   // Lane extraction and sign/zero extension of the returned word
   always_comb begin
      byte_v = 8'(rdata >> {lo_q, 3'b000});
      half_v = 16'(rdata >> {lo_q[1], 4'b0000});
      case (f3_q)
         3'b000:  ext_v = {{24{byte_v[7]}}, byte_v};
         3'b001:  ext_v = {{16{half_v[15]}}, half_v};
         3'b010:  ext_v = rdata;
         3'b100:  ext_v = {24'h0, byte_v};
         3'b101:  ext_v = {16'h0, half_v};
         default: ext_v = '0;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      lo_d     = lo_q;
      araddr_d = araddr_q;
      data_d   = data_q;
      rd_d     = rd_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               f3_d = req_funct3;
               lo_d = req_addr[1:0];
               rd_d = req_rd;
               if (req_legal && !req_misal) begin
                  araddr_d = {req_addr[31:2], 2'b00};
                  state_d  = S_AR;
               end else begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_AR: begin
            if (arready) state_d = S_R;
         end
         S_R: begin
            if (rvalid) begin
               err_d   = (rresp != 2'b00);
               data_d  = (rresp != 2'b00) ? '0 : ext_v;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, payload and registered status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         f3_q         <= '0;
         lo_q         <= '0;
         araddr_q     <= '0;
         data_q       <= '0;
         rd_q         <= '0;
         err_q        <= 1'b0;
         req_ready_q  <= 1'b1;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         f3_q         <= f3_d;
         lo_q         <= lo_d;
         araddr_q     <= araddr_d;
         data_q       <= data_d;
         rd_q         <= rd_d;
         err_q        <= err_d;
         req_ready_q  <= (state_d == S_IDLE);
         arvalid_q    <= (state_d == S_AR);
         rready_q     <= (state_d == S_R);
         resp_valid_q <= (state_d == S_RESP);
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign req_ready  = req_ready_q;
   assign araddr     = araddr_q;
   assign arvalid    = arvalid_q;
   assign rready     = rready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = data_q;
   assign resp_rd    = rd_q;
   assign resp_err   = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_lsu_load.sv
// Bench for lsu_load: cycle-timeline expectations from a load-semantics model,
// checked every cycle, plus directed literal cases.
module tb_lsu_load;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [4:0]  req_rd;
   logic [31:0] araddr;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err, busy;

   int n_chk = 0;
   int n_pass = 0;

   // Per-cycle expectations written by the driver, read by the checker
   logic        chk_on = 1'b0;
   logic        e_req_ready, e_busy, e_arvalid, e_rready, e_resp_valid, e_zero;
   logic [31:0] e_araddr, e_resp_data;
   logic [4:0]  e_resp_rd;
   logic        e_resp_err;

   lsu_load dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_funct3(req_funct3), .req_rd(req_rd),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Load semantics: {err, data}
   function automatic logic [32:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d, input logic [1:0] rr);
      int unsigned sz, sh;
      logic [63:0] t, mask;
      longint v;
      case (f3)
         3'd0, 3'd4: sz = 1;
         3'd1, 3'd5: sz = 2;
         3'd2:       sz = 4;
         default:    return {1'b1, 32'h0};
      endcase
      if ((a % sz) != 0) return {1'b1, 32'h0};
      if (rr != 2'b00) return {1'b1, 32'h0};
      sh   = ((a % 4) / sz) * sz * 8;
      t    = {32'h0, d} >> sh;
      mask = (64'd1 << (sz * 8)) - 64'd1;
      v    = longint'(t & mask);
      if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (sz * 8 - 1)))
         v = v - (longint'(1) << (sz * 8));
      return {1'b0, 32'(v)};
   endfunction

   // Checker: compares every cycle at the falling edge
   always @(negedge clk) begin
      if (chk_on) begin
         chk("req_ready",  32'(req_ready),  32'(e_req_ready));
         chk("busy",       32'(busy),       32'(e_busy));
         chk("arvalid",    32'(arvalid),    32'(e_arvalid));
         chk("rready",     32'(rready),     32'(e_rready));
         chk("resp_valid", 32'(resp_valid), 32'(e_resp_valid));
         if (e_arvalid || e_zero) chk("araddr", araddr, e_zero ? 32'h0 : e_araddr);
         if (e_resp_valid || e_zero) begin
            chk("resp_data", resp_data,        e_zero ? 32'h0 : e_resp_data);
            chk("resp_rd",   32'(resp_rd),     e_zero ? 32'h0 : 32'(e_resp_rd));
            chk("resp_err",  32'(resp_err),    e_zero ? 32'h0 : 32'(e_resp_err));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_phase(input int ph);
      // 0 idle, 1 addr, 2 data, 3 response
      e_req_ready  = (ph == 0);
      e_busy       = (ph != 0);
      e_arvalid    = (ph == 1);
      e_rready     = (ph == 2);
      e_resp_valid = (ph == 3);
   endtask

   task automatic junk_inputs();
      req_valid  = 1'($urandom);
      req_addr   = $urandom;
      req_funct3 = 3'($urandom);
      req_rd     = 5'($urandom);
      rdata      = $urandom;
      rresp      = 2'($urandom);
   endtask

   task automatic txn(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] d, input logic [1:0] rr,
                      input int ar_dly, input int r_dly, input int resp_dly,
                      input bit lit, input logic [31:0] lit_d, input bit lit_e);
      logic [32:0] res;
      bit pre_err;
      pre_err = model(f3, a, 32'h0, 2'b00) >> 32 != 0;
      res     = model(f3, a, d, rr);
      // acceptance cycle
      exp_phase(0); e_zero = 1'b0;
      req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_rd = rd;
      arready = 1'b0; rvalid = 1'b0; resp_ready = 1'b0;
      step();
      if (!pre_err) begin
         for (int i = 0; i <= ar_dly; i++) begin
            exp_phase(1); e_araddr = {a[31:2], 2'b00};
            junk_inputs();
            rvalid = 1'($urandom); arready = (i == ar_dly);
            step();
         end
         arready = 1'b0;
         for (int i = 0; i <= r_dly; i++) begin
            exp_phase(2);
            junk_inputs();
            rvalid = (i == r_dly);
            if (i == r_dly) begin rdata = d; rresp = rr; end
            step();
         end
      end
      for (int i = 0; i <= resp_dly; i++) begin
         exp_phase(3);
         e_resp_data = res[31:0]; e_resp_err = res[32]; e_resp_rd = rd;
         junk_inputs();
         rvalid = 1'($urandom); arready = 1'($urandom);
         resp_ready = (i == resp_dly);
         if (lit && i == 0) begin
            chk("lit_data", resp_data, lit_d);
            chk("lit_err",  32'(resp_err), 32'(lit_e));
         end
         step();
      end
      resp_ready = 1'b0; arready = 1'b0; rvalid = 1'b0; req_valid = 1'b0;
      exp_phase(0);
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         exp_phase(0);
         junk_inputs();
         req_valid = 1'b0; rvalid = 1'($urandom); arready = 1'($urandom);
         resp_ready = 1'($urandom);
         step();
      end
      rvalid = 1'b0; arready = 1'b0; resp_ready = 1'b0;
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [1:0]  rr;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
      arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0; resp_ready = 1'b0;
      e_araddr = '0; e_resp_data = '0; e_resp_rd = '0; e_resp_err = 1'b0;
      exp_phase(0); e_zero = 1'b1;
      step();
      chk_on = 1'b1;
      step();
      rst = 1'b0;
      step();
      e_zero = 1'b0;

      // Directed cases with literal expectations
      txn(3'b010, 32'h8000_0010, 5'd5,  32'hDEAD_BEEF, 2'b00, 0, 0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      txn(3'b000, 32'h8000_0013, 5'd6,  32'h80AA_BBCC, 2'b00, 0, 0, 0, 1'b1, 32'hFFFF_FF80, 1'b0);
      txn(3'b100, 32'h8000_0013, 5'd7,  32'h80AA_BBCC, 2'b00, 0, 0, 0, 1'b1, 32'h0000_0080, 1'b0);
      txn(3'b001, 32'h8000_0002, 5'd8,  32'h1234_5678, 2'b00, 0, 0, 0, 1'b1, 32'h0000_1234, 1'b0);
      txn(3'b001, 32'h8000_0001, 5'd9,  32'h1234_5678, 2'b00, 0, 0, 0, 1'b1, 32'h0000_0000, 1'b1);
      txn(3'b010, 32'h8000_0020, 5'd10, 32'hCAFE_F00D, 2'b00, 5, 1, 3, 1'b1, 32'hCAFE_F00D, 1'b0);
      txn(3'b010, 32'h8000_0024, 5'd11, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 1'b1, 32'h0000_0000, 1'b1);
      txn(3'b101, 32'h0000_0102, 5'd12, 32'h9ABC_1234, 2'b00, 1, 2, 1, 1'b1, 32'h0000_9ABC, 1'b0);
      txn(3'b011, 32'h0000_0100, 5'd13, 32'h9ABC_1234, 2'b00, 0, 0, 0, 1'b1, 32'h0000_0000, 1'b1);
      idle_gap(3);

      // Reset while waiting for read data abandons the load
      exp_phase(0);
      req_valid = 1'b1; req_addr = 32'h8000_0040; req_funct3 = 3'b010; req_rd = 5'd3;
      step();
      req_valid = 1'b0; exp_phase(1); e_araddr = 32'h8000_0040; arready = 1'b1;
      step();
      arready = 1'b0; exp_phase(2); rst = 1'b1;
      step();
      rst = 1'b0; exp_phase(0); e_zero = 1'b1;
      rvalid = 1'b1; rdata = 32'h1111_2222; rresp = 2'b00;
      step();
      rvalid = 1'b0;
      step();
      step();
      e_zero = 1'b0;

      // Randomized loads
      for (int n = 0; n < 200; n++) begin
         f3 = 3'($urandom);
         a  = $urandom;
         rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         txn(f3, a, 5'($urandom), $urandom, rr,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
             1'b0, 32'h0, 1'b0);
         if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 2));
      end

      step();
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lsu_load.md
LSU_LOAD -- requirements
Module: lsu_load

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  load request from execute stage.
REQ-005 req_ready  output  1  high only in IDLE.
REQ-006 req_addr  input  32  byte address of the load.
REQ-007 req_funct3  input  3  load type:
- 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
- all other codes are illegal.
REQ-008 req_rd  input  5  destination tag, returned unchanged.
REQ-009 araddr  output  32  AXI-lite read address, word-aligned.
REQ-010 arvalid  output  1  AXI-lite read address valid.
REQ-011 arready  input  1  from the read arbiter, port A.
REQ-012 rdata  input  32  read data.
REQ-013 rresp  input  2  read response; 2'b00 means OKAY.
REQ-014 rvalid  input  1  read data valid.
REQ-015 rready  output  1  read data ready.
REQ-016 resp_valid  output  1  load result valid to writeback.
REQ-017 resp_ready  input  1  writeback accepts the result.
REQ-018 resp_data  output  32  extended load result.
REQ-019 resp_rd  output  5  captured req_rd.
REQ-020 resp_err  output  1  misaligned, illegal funct3, or non-OKAY rresp.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 SHALL implement the FSM IDLE, AR, R, RESP; all outputs are registered or decoded from state only.
REQ-023 IDLE: on req_valid, capture addr, funct3 and rd.
- Legal and aligned request: go to AR.
- Otherwise: go to RESP with resp_err=1 and resp_data=0; no AXI traffic is issued.
REQ-024 Alignment rules:
- LH/LHU are misaligned if addr[0]=1.
- LW is misaligned if addr[1:0]!=0.
- Byte loads are never misaligned.
REQ-025 AR state:
- arvalid=1 and araddr={addr[31:2],2'b00}, both held stable until arready.
- arvalid SHALL NOT drop before arready.
- On arvalid&&arready, go to R.
REQ-026 R state:
- rready=1.
- On rvalid, capture extracted data and err=(rresp!=0), then go to RESP.
- rdata arriving outside R is ignored.
REQ-027 Extraction by addr[1:0]:
- Byte = rdata[8*addr[1:0]+:8].
- Half = rdata[16*addr[1]+:16].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata unchanged.
REQ-028 On rresp!=0, resp_data SHALL be 0.
REQ-029 RESP state:
- resp_valid=1, with resp_data/resp_rd/resp_err held stable.
- On resp_ready, go to IDLE.
REQ-030 Minimum latency, cycle 0 = request accepted:
- arvalid in cycle 1.
- With arready in cycle 1 and rvalid in cycle 2, resp_valid in cycle 3.
REQ-031 An error request SHALL produce resp_valid in cycle 1.
REQ-032 A new request SHALL NOT be accepted in the cycle resp_ready completes; req_ready rises the following cycle.
REQ-033 rready SHALL be 0 outside R; arvalid SHALL be 0 outside AR.

Reset
REQ-034 While rst is high, SHALL go to IDLE next edge and drive:
- arvalid=0, rready=0, resp_valid=0;
- resp_data=0, resp_rd=0, resp_err=0;
- araddr=0, busy=0.
REQ-035 Reset mid-transaction SHALL abandon it; rvalid arriving after reset is ignored because the block is in IDLE.

Verification
REQ-036 LW, addr 0x8000_0010; arready in cycle 1, rdata 0xDEAD_BEEF in cycle 2 -> araddr 0x8000_0010; resp_data 0xDEAD_BEEF in cycle 3; resp_err=0.
REQ-037 LB at 0x8000_0013, rdata 0x80AA_BBCC -> resp_data 0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
REQ-038 LH at 0x8000_0002, rdata 0x1234_5678 -> 0x0000_1234; LH at 0x8000_0001 -> resp_err=1, data 0, arvalid never asserted.
REQ-039 Back-pressure case:
- arready low 5 cycles -> arvalid and araddr stable throughout;
- resp_ready low 3 cycles -> resp_valid and data held;
- req_ready=0 throughout.
REQ-040 rresp=2'b10 on an LW -> resp_err=1, resp_data=0.
REQ-041 rst asserted while in R -> IDLE next cycle; a subsequent rvalid pulse produces no resp_valid.
